// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nn_pkg
// Brief   : Q15.16 number format, layer weight/bias tables and saturation
//           helpers shared by the fully-connected layer blocks.
// Revision: 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int FRAC_BITS = 16;
    localparam int ACC_W     = 48;
    localparam int N_IN      = 6;
    localparam int N_OUT     = 4;

    typedef logic signed [31:0]      q_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam q_t SAT_MAX = 32'sh7FFF_FFFF;
    localparam q_t SAT_MIN = 32'sh8000_0000;
    localparam q_t Q_ONE   = 32'sh0001_0000;
    localparam q_t Q_HALF  = 32'sh0000_8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Zero-based indices: neuron j draws 1.0 from input j and 0.5 from input j+2.
    function automatic q_t l1_weight(input int j, input int i);
        if (i == j) begin
            return Q_ONE;
        end else if (i == j + 2) begin
            return Q_HALF;
        end else begin
            return '0;
        end
    endfunction

    function automatic q_t l1_bias(input int j);
        case (j)
            0:       return Q_ONE;
            1:       return 32'shFFFF_0000;
            2:       return Q_HALF;
            default: return '0;
        endcase
    endfunction

    function automatic q_t sat_relu(input acc_t a);
        acc_t c;
        if (a > acc_t'(SAT_MAX)) begin
            c = acc_t'(SAT_MAX);
        end else if (a < acc_t'(SAT_MIN)) begin
            c = acc_t'(SAT_MIN);
        end else begin
            c = a;
        end
        return c[ACC_W-1] ? '0 : q_t'(c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac.sv
`default_nettype none
// ============================================================================
// Module  : mac
// Brief   : Signed 32x32 multiply, Q15.16 rescale (floor), 48-bit accumulate.
// Revision: 1.0 - initial release
// ============================================================================
module mac
    import nn_pkg::*;
(
    input  logic clk_i,
    input  logic clr_i,
    input  logic en_i,
    input  q_t   w_i,
    input  q_t   x_i,
    output acc_t acc_o
);

    logic signed [63:0] prod;
    acc_t               acc_q;
    acc_t               acc_d;

    assign prod = w_i * x_i;

    // Arithmetic shift floors toward minus infinity; the result always fits 48 bits.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + acc_t'(prod >>> FRAC_BITS);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/layer6to4.sv
`default_nettype none
// ============================================================================
// Module  : layer6to4
// Brief   : 6-input / 4-neuron fully-connected ReLU layer, one input per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module layer6to4
    import nn_pkg::*;
(
    input  logic        clk_x70,
    input  logic        reset_x70,
    input  logic [31:0] x1_x70,
    input  logic [31:0] x2_x70,
    input  logic [31:0] x3_x70,
    input  logic [31:0] x4_x70,
    input  logic [31:0] x5_x70,
    input  logic [31:0] x6_x70,
    output logic [31:0] y1_x70,
    output logic [31:0] y2_x70,
    output logic [31:0] y3_x70,
    output logic [31:0] y4_x70,
    output logic        done_x70
);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic       done_q, done_d;
    q_t         x_q [N_IN];
    q_t         y_q [N_OUT];
    q_t         y_d [N_OUT];
    acc_t       acc [N_OUT];
    logic       mac_en;
    q_t         x_sel;

    always_ff @(posedge clk_x70) begin
        if (reset_x70) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            done_q  <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                y_q[j] <= '0;
            end
            x_q[0] <= x1_x70;
            x_q[1] <= x2_x70;
            x_q[2] <= x3_x70;
            x_q[3] <= x4_x70;
            x_q[4] <= x5_x70;
            x_q[5] <= x6_x70;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (step_q == 3'(i)) begin
                x_sel = x_q[i];
            end
        end
    end

    // Steps 0..5 accumulate; a counter value of 6 marks the bias/saturate edge.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = done_q;
        y_d     = y_q;
        mac_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mac_en  = 1'b1;
                step_d  = 3'd1;
                state_d = ST_ACC;
            end
            ST_ACC: begin
                if (step_q <= 3'd5) begin
                    mac_en = 1'b1;
                    step_d = step_q + 3'd1;
                end else begin
                    for (int j = 0; j < N_OUT; j++) begin
                        y_d[j] = sat_relu(acc[j] + acc_t'(l1_bias(j)));
                    end
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
        q_t w;
        assign w = l1_weight(j, int'(step_q));

        mac u_mac (
            .clk_i (clk_x70),
            .clr_i (reset_x70),
            .en_i  (mac_en),
            .w_i   (w),
            .x_i   (x_sel),
            .acc_o (acc[j])
        );
    end

    assign y1_x70   = y_q[0];
    assign y2_x70   = y_q[1];
    assign y3_x70   = y_q[2];
    assign y4_x70   = y_q[3];
    assign done_x70 = done_q;

endmodule
`default_nettype wire

// File: tb/tb_layer6to4.sv
`default_nettype none
// ============================================================================
// Module  : tb_layer6to4
// Brief   : Directed vector bench for layer6to4 with hand-computed results.
// Revision: 1.0 - initial release
// ============================================================================
module tb_layer6to4;

    typedef struct packed {
        logic [5:0][31:0] x;
        logic [3:0][31:0] y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x1, x2, x3, x4, x5, x6;
    logic [31:0] y1, y2, y3, y4;
    logic        done;

    int total = 0;
    int bad   = 0;

    vec_t tbl [6];

    always #5 clk = ~clk;

    layer6to4 dut (
        .clk_x70   (clk),
        .reset_x70 (rst),
        .x1_x70    (x1),
        .x2_x70    (x2),
        .x3_x70    (x3),
        .x4_x70    (x4),
        .x5_x70    (x5),
        .x6_x70    (x6),
        .y1_x70    (y1),
        .y2_x70    (y2),
        .y3_x70    (y3),
        .y4_x70    (y4),
        .done_x70  (done)
    );

    function automatic vec_t mk(input logic [31:0] a1, a2, a3, a4, a5, a6,
                                input logic [31:0] e1, e2, e3, e4);
        vec_t v;
        v.x[0] = a1; v.x[1] = a2; v.x[2] = a3;
        v.x[3] = a4; v.x[4] = a5; v.x[5] = a6;
        v.y[0] = e1; v.y[1] = e2; v.y[2] = e3; v.y[3] = e4;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_x(input vec_t v);
        x1 = v.x[0]; x2 = v.x[1]; x3 = v.x[2];
        x4 = v.x[3]; x5 = v.x[4]; x6 = v.x[5];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " rst done"}, {31'd0, done}, 32'd0);
        check({tag, " rst y1"}, y1, 32'd0);
        check({tag, " rst y2"}, y2, 32'd0);
        check({tag, " rst y3"}, y3, 32'd0);
        check({tag, " rst y4"}, y4, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 32'd7);
    endtask

    task automatic check_y(input string tag, input vec_t v);
        check({tag, " y1"}, y1, v.y[0]);
        check({tag, " y2"}, y2, v.y[1]);
        check({tag, " y3"}, y3, v.y[2]);
        check({tag, " y4"}, y4, v.y[3]);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        rst = 1'b1;
        set_x(v);
        tick();
        check_cleared(tag);
        rst = 1'b0;
        wait_done(tag);
        check_y(tag, v);
    endtask

    initial begin
        rst = 1'b1;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0; x5 = '0; x6 = '0;

        tbl[0] = mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                    32'h0001_0000, 32'h0001_0000,
                    32'h0002_8000, 32'h0000_8000, 32'h0002_0000, 32'h0001_8000);
        tbl[1] = mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0);
        tbl[2] = mk(32'h7FFF_0000, 32'hFFFC_0000, 32'h7FFF_0000, 32'h0, 32'h0, 32'h0,
                    32'h7FFF_FFFF, 32'h0, 32'h7FFF_8000, 32'h0);
        // 0.5 * -1 lsb floors to -1 lsb
        tbl[3] = mk(32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                    32'h0000_FFFF, 32'h0, 32'h0000_7FFF, 32'h0);
        tbl[4] = mk(32'h0002_0000, 32'h0003_0000, 32'h0000_0003, 32'hFFFE_0000,
                    32'h0001_0000, 32'h0005_0000,
                    32'h0003_0001, 32'h0001_0000, 32'h0001_0003, 32'h0000_8000);
        tbl[5] = mk(32'h8000_0000, 32'h0, 32'h0, 32'h7FFF_0000, 32'h0, 32'h7FFF_0000,
                    32'h0, 32'h3FFE_8000, 32'h0000_8000, 32'h7FFF_FFFF);

        repeat (2) tick();

        for (int k = 0; k < 6; k++) begin
            run_vec($sformatf("vec%0d", k), tbl[k]);
        end

        // Abort on the third accumulation edge, then restart with new inputs.
        rst = 1'b1;
        set_x(tbl[4]);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        set_x(tbl[5]);
        tick();
        check_cleared("abort");
        rst = 1'b0;
        wait_done("abort");
        check_y("abort", tbl[5]);

        // Outputs must hold while inputs wander after completion.
        for (int c = 0; c < 20; c++) begin
            x1 = 32'h1234_5678 * (c + 1);
            x2 = ~x1;
            x3 = x1 ^ 32'h5A5A_5A5A;
            x4 = 32'hFFFF_0000 - x1;
            x5 = {x1[15:0], x1[31:16]};
            x6 = x1 + 32'h0007_0000;
            tick();
            check($sformatf("hold%0d done", c), {31'd0, done}, 32'd1);
            check($sformatf("hold%0d y2", c), y2, tbl[5].y[1]);
        end
        check_y("hold end", tbl[5]);

        rst = 1'b1;
        tick();
        check_cleared("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
